sa_stream_decoder: RTL

Downstream companion to `sa_bitstream_gen`. It consumes the generator's serial streaming-accurate bitstream one bit per enabled cycle and counts the ones over a window of L = 2^N bits. At window end it presents the recovered value k on a valid/ready result port. It is the decode stage of the SA compress/decompress loop, and it also serves as a hardware self-check against the value driven into the generator.

---
 rtl/sa_stream_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sa_stream_decoder.sv
// Counts the ones in an L-bit window of a serial stream and returns the count on a valid/ready port.
// Defining SA_DEC_CHECK_EN adds the k_ref/match ports, which compare the result against a reference value.
module sa_stream_decoder #(
    parameter int N = 7,
    parameter int L = 1 << N
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SA_DEC_CHECK_EN
    input  logic [N-1:0] k_ref,
    output logic         match,
`endif
    input  logic         start,
    input  logic         bit_valid,
    input  logic         bit_in,
    output logic [N:0]   count_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [N:0]   bit_idx,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [N:0] LAST_IDX = (N+1)'(L - 1);

    state_t     state, state_nx;
    logic [N:0] ones, ones_nx, bit_idx_nx, count_nx;
    logic       out_valid_nx, overrun_nx, busy_nx, start_acc;
    logic [N:0] ones_inc;

    // The sum includes the current bit, so the closing edge latches the full window.
    assign ones_inc = ones + {{N{1'b0}}, bit_in};

`ifdef SA_DEC_CHECK_EN
    logic [N-1:0] k_ref_q, k_ref_nx;
    logic         match_nx;
`endif

    always_comb begin
        state_nx     = state;
        ones_nx      = ones;
        bit_idx_nx   = bit_idx;
        count_nx     = count_out;
        out_valid_nx = out_valid;
        overrun_nx   = overrun;
        start_acc    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nx  = ACCUM;
                end
            end
            ACCUM: begin
                // A start colliding with a valid bit wins: the bit is discarded.
                if (start) begin
                    start_acc = 1'b1;
                end else if (bit_valid) begin
                    ones_nx    = ones_inc;
                    bit_idx_nx = bit_idx + (N+1)'(1);
                    if (bit_idx == LAST_IDX) begin
                        count_nx     = ones_inc;
                        out_valid_nx = 1'b1;
                        state_nx     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready && start) begin
                    out_valid_nx = 1'b0;
                    start_acc    = 1'b1;
                    state_nx     = ACCUM;
                end else begin
                    if (out_ready) begin
                        out_valid_nx = 1'b0;
                        state_nx     = IDLE;
                    end
                    if (start || bit_valid) overrun_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start_acc) begin
            ones_nx    = '0;
            bit_idx_nx = '0;
            overrun_nx = 1'b0;
        end
        busy_nx = (state_nx == ACCUM);
    end

`ifdef SA_DEC_CHECK_EN
    always_comb begin
        k_ref_nx = k_ref_q;
        match_nx = match;
        if (start_acc) begin
            k_ref_nx = k_ref;
            match_nx = 1'b0;
        end else if (state == ACCUM && bit_valid && bit_idx == LAST_IDX) begin
            match_nx = (ones_inc == {1'b0, k_ref_q});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_ref_q <= '0;
            match   <= 1'b0;
        end else begin
            k_ref_q <= k_ref_nx;
            match   <= match_nx;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ones      <= '0;
            bit_idx   <= '0;
            count_out <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            ones      <= ones_nx;
            bit_idx   <= bit_idx_nx;
            count_out <= count_nx;
            out_valid <= out_valid_nx;
            overrun   <= overrun_nx;
            busy      <= busy_nx;
        end
    end

endmodule
